// File: rtl/score_tracker_if.sv
// score_tracker_if
// Groups the game-side signals of the score tracker into one bundle.
//   reached_target : level from the game logic, each 0->1 edge is one point
//   restart        : synchronous new-game request
//   score_bcd      : current score, packed BCD, LS digit in [3:0]
//   high_score_bcd : best score since reset, packed BCD
//   score_pulse    : one-cycle strobe per accepted point
//   win            : high while the game is won
// The master modport is the game side, the slave modport is the tracker.
interface score_tracker_if #(
  parameter int DIGITS = 2
);
  logic                  reached_target;
  logic                  restart;
  logic [4*DIGITS-1:0]   score_bcd;
  logic [4*DIGITS-1:0]   high_score_bcd;
  logic                  score_pulse;
  logic                  win;

  modport master (
    output reached_target,
    output restart,
    input  score_bcd,
    input  high_score_bcd,
    input  score_pulse,
    input  win
  );

  modport slave (
    input  reached_target,
    input  restart,
    output score_bcd,
    output high_score_bcd,
    output score_pulse,
    output win
  );
endinterface

// File: rtl/score_tracker.sv
// score_tracker
// Counts points from rising edges of a game "target reached" level in BCD,
// declares a win when the score reaches WIN_SCORE, and tracks the best score
// seen since reset.
//   clk : single clock, all state updates on its rising edge
//   rst : asynchronous active-high reset, clears everything incl. high score
//   bus : score_tracker_if.slave (reached_target, restart in;
//         score_bcd, high_score_bcd, score_pulse, win out)
// Parameters:
//   DIGITS    : BCD digits per score value, 1..4
//   WIN_SCORE : winning score (decimal), 1..10^DIGITS-1
module score_tracker #(
  parameter int DIGITS    = 2,
  parameter int WIN_SCORE = 10
) (
  input  logic           clk,
  input  logic           rst,
  score_tracker_if.slave bus
);

  localparam int W         = 4 * DIGITS;
  localparam int MAX_SCORE = (10 ** DIGITS) - 1;

  // Illegal parameter combinations stop elaboration.
  generate
    if (DIGITS < 1 || DIGITS > 4) begin : g_bad_digits
      $error("score_tracker: DIGITS must be in 1..4");
    end
    if (WIN_SCORE < 1 || WIN_SCORE > MAX_SCORE) begin : g_bad_win
      $error("score_tracker: WIN_SCORE out of range for DIGITS");
    end
  endgenerate

  // Decimal to packed BCD, used only on constants.
  function automatic logic [W-1:0] to_bcd(input int value);
    int v;
    to_bcd = '0;
    v      = value;
    for (int i = 0; i < DIGITS; i++) begin
      to_bcd[4*i +: 4] = 4'(v % 10);
      v                = v / 10;
    end
  endfunction

  localparam logic [W-1:0] WIN_BCD = to_bcd(WIN_SCORE);

  typedef enum logic {
    PLAYING = 1'b0,
    WON     = 1'b1
  } state_t;

  state_t         state;
  state_t         state_next;
  logic           prev_target;
  logic           hit;
  logic [W-1:0]   score;
  logic [W-1:0]   score_inc;
  logic [W-1:0]   high_score;
  logic           score_pulse;
  logic           win;

  assign hit = bus.reached_target & ~prev_target;

  // Ripple BCD increment: a 9 rolls to 0 and carries into the next digit.
  always_comb begin
    logic carry;
    score_inc = score;
    carry     = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (score[4*i +: 4] == 4'd9) begin
          score_inc[4*i +: 4] = 4'd0;
        end else begin
          score_inc[4*i +: 4] = score[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= PLAYING;
    end else begin
      state <= state_next;
    end
  end

  // Restart overrides everything; the win is taken on the same edge as the
  // increment that lands exactly on WIN_SCORE.
  always_comb begin
    state_next = state;
    if (bus.restart) begin
      state_next = PLAYING;
    end else if (state == PLAYING && hit && score_inc == WIN_BCD) begin
      state_next = WON;
    end
  end

  always_comb begin
    win = (state == WON);
  end

  // The edge detector samples every cycle, restart included, so a level held
  // across a restart is not counted twice. The high score compares the
  // pre-edge score, which gives the one-cycle lag and lets it see the score
  // that a restart is about to clear. Valid BCD compares correctly as binary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_target <= 1'b0;
      score       <= '0;
      score_pulse <= 1'b0;
      high_score  <= '0;
    end else begin
      prev_target <= bus.reached_target;
      if (score > high_score) begin
        high_score <= score;
      end
      if (bus.restart) begin
        score       <= '0;
        score_pulse <= 1'b0;
      end else if (hit && state == PLAYING) begin
        score       <= score_inc;
        score_pulse <= 1'b1;
      end else begin
        score_pulse <= 1'b0;
      end
    end
  end

  assign bus.score_bcd      = score;
  assign bus.high_score_bcd = high_score;
  assign bus.score_pulse    = score_pulse;
  assign bus.win            = win;

endmodule

// File: tb/tb_score_tracker.sv
// tb_score_tracker
// Self-checking bench for score_tracker. Two instances with DIGITS=2 share
// the same inputs: one with WIN_SCORE=10, one with WIN_SCORE=99. A decimal
// reference model predicts both every cycle; a vector table and hand-written
// sequences add explicit expectations for the interesting corners.
module tb_score_tracker;

  localparam int DIGITS = 2;
  localparam int W      = 4 * DIGITS;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rt  = 1'b0;
  logic rs  = 1'b0;

  always #5 clk = ~clk;

  score_tracker_if #(.DIGITS(DIGITS)) bus10 ();
  score_tracker_if #(.DIGITS(DIGITS)) bus99 ();

  assign bus10.reached_target = rt;
  assign bus10.restart        = rs;
  assign bus99.reached_target = rt;
  assign bus99.restart        = rs;

  score_tracker #(.DIGITS(DIGITS), .WIN_SCORE(10)) dut10 (
    .clk (clk),
    .rst (rst),
    .bus (bus10.slave)
  );

  score_tracker #(.DIGITS(DIGITS), .WIN_SCORE(99)) dut99 (
    .clk (clk),
    .rst (rst),
    .bus (bus99.slave)
  );

  int total = 0;
  int bad   = 0;

  // Decimal reference model, index 0 = WIN_SCORE 10, index 1 = WIN_SCORE 99.
  int m_score [2];
  int m_high  [2];
  bit m_won   [2];
  bit m_pulse [2];
  bit m_prev;
  int win_val [2] = '{10, 99};

  function automatic logic [W-1:0] bcd(input int v);
    logic [W-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x           = x / 10;
    end
    return r;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      m_score[k] = 0;
      m_high[k]  = 0;
      m_won[k]   = 1'b0;
      m_pulse[k] = 1'b0;
    end
    m_prev = 1'b0;
  endtask

  task automatic modelStep(input bit t, input bit r);
    bit is_hit;
    int best;
    is_hit = t && !m_prev;
    for (int k = 0; k < 2; k++) begin
      best = (m_score[k] > m_high[k]) ? m_score[k] : m_high[k];
      if (r) begin
        m_score[k] = 0;
        m_won[k]   = 1'b0;
        m_pulse[k] = 1'b0;
      end else if (is_hit && !m_won[k]) begin
        m_score[k] = m_score[k] + 1;
        m_pulse[k] = 1'b1;
        if (m_score[k] == win_val[k]) m_won[k] = 1'b1;
      end else begin
        m_pulse[k] = 1'b0;
      end
      m_high[k] = best;
    end
    m_prev = t;
  endtask

  function automatic logic [2*W+1:0] expectedOut(input int k);
    return {bcd(m_score[k]), bcd(m_high[k]), m_pulse[k], m_won[k]};
  endfunction

  function automatic logic [2*W+1:0] actualOut(input int k);
    if (k == 0)
      return {bus10.score_bcd, bus10.high_score_bcd, bus10.score_pulse, bus10.win};
    return {bus99.score_bcd, bus99.high_score_bcd, bus99.score_pulse, bus99.win};
  endfunction

  task automatic checkOutput(input string name);
    logic [2*W+1:0] got;
    logic [2*W+1:0] want;
    for (int k = 0; k < 2; k++) begin
      got  = actualOut(k);
      want = expectedOut(k);
      total++;
      if (got !== want) begin
        bad++;
        $display("[TB] FAIL %s win%0d: got score=%h high=%h pulse=%b win=%b, want score=%h high=%h pulse=%b win=%b",
                 name, win_val[k], got[2*W+1 -: W], got[W+1 -: W], got[1], got[0],
                 want[2*W+1 -: W], want[W+1 -: W], want[1], want[0]);
      end
    end
  endtask

  task automatic checkValue(input string name, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // Called just after a rising edge: drive inputs, take the next edge, then
  // sample 1 time unit later.
  task automatic applyStimulus(input bit t, input bit r);
    rt = t;
    rs = r;
    @(posedge clk);
    modelStep(t, r);
    #1;
  endtask

  task automatic doReset(input string name);
    rst = 1'b1;
    rt  = 1'b0;
    rs  = 1'b0;
    modelReset();
    #1;
    checkOutput(name);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    bit           rt;
    bit           rs;
    logic [W-1:0] score;
    bit           pulse;
    bit           win;
    logic [W-1:0] high;
  } vec_t;

  vec_t tbl [18];

  initial begin
    int pulses;

    // Expectations for the WIN_SCORE=10 instance starting from reset.
    tbl[0]  = '{1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 8'h01};
    tbl[2]  = '{1'b1, 1'b0, 8'h02, 1'b1, 1'b0, 8'h01};
    tbl[3]  = '{1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 8'h02};
    tbl[4]  = '{1'b1, 1'b0, 8'h03, 1'b1, 1'b0, 8'h02};
    tbl[5]  = '{1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 8'h03};
    tbl[6]  = '{1'b1, 1'b0, 8'h04, 1'b1, 1'b0, 8'h03};
    tbl[7]  = '{1'b1, 1'b0, 8'h04, 1'b0, 1'b0, 8'h04};
    tbl[8]  = '{1'b1, 1'b0, 8'h04, 1'b0, 1'b0, 8'h04};
    tbl[9]  = '{1'b0, 1'b0, 8'h04, 1'b0, 1'b0, 8'h04};
    tbl[10] = '{1'b1, 1'b0, 8'h05, 1'b1, 1'b0, 8'h04};
    tbl[11] = '{1'b0, 1'b0, 8'h05, 1'b0, 1'b0, 8'h05};
    tbl[12] = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h05};
    tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h05};
    tbl[14] = '{1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 8'h05};
    tbl[15] = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h05};
    tbl[16] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h05};
    tbl[17] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h05};

    #2;
    doReset("reset");

    for (int i = 0; i < 18; i++) begin
      applyStimulus(tbl[i].rt, tbl[i].rs);
      checkValue($sformatf("table[%0d]", i),
                 int'({bus10.score_bcd, bus10.high_score_bcd, bus10.score_pulse, bus10.win}),
                 int'({tbl[i].score, tbl[i].high, tbl[i].pulse, tbl[i].win}));
      checkOutput($sformatf("table_model[%0d]", i));
    end

    // Level held for 20 cycles is one point.
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b0);
      pulses += int'(bus10.score_pulse);
      checkOutput("hold");
    end
    applyStimulus(1'b0, 1'b0);
    checkValue("hold_pulses", pulses, 1);
    checkValue("hold_score", int'(bus10.score_bcd), 'h01);

    // Climb to 09, win on 10, saturate, then restart.
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
    end
    checkValue("pre_win_score", int'(bus10.score_bcd), 'h09);
    applyStimulus(1'b1, 1'b0);
    checkValue("win_edge", int'({bus10.score_bcd, bus10.score_pulse, bus10.win}),
               int'({8'h10, 1'b1, 1'b1}));
    checkOutput("win_edge_model");
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkValue("won_ignore", int'({bus10.score_bcd, bus10.score_pulse, bus10.win}),
                 int'({8'h10, 1'b0, 1'b1}));
      applyStimulus(1'b0, 1'b0);
    end
    applyStimulus(1'b0, 1'b1);
    checkValue("won_restart", int'({bus10.score_bcd, bus10.high_score_bcd, bus10.win}),
               int'({8'h00, 8'h10, 1'b0}));
    checkOutput("won_restart_model");

    // 25 hits on the WIN_SCORE=99 instance, high score one cycle behind.
    doReset("reset2");
    for (int i = 0; i < 25; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("count25");
      applyStimulus(1'b0, 1'b0);
    end
    checkValue("count25_final", int'({bus99.score_bcd, bus99.high_score_bcd}),
               int'({8'h25, 8'h25}));
    checkValue("win10_saturated", int'({bus10.score_bcd, bus10.win}), int'({8'h10, 1'b1}));

    // Asynchronous reset between edges at score 07, then a level already
    // high at the first edge after release.
    doReset("reset3");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
    end
    checkValue("pre_async_score", int'(bus10.score_bcd), 'h07);
    #2;
    rst = 1'b1;
    modelReset();
    #1;
    checkOutput("async_reset");
    rt = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0);
    checkValue("first_edge_hit", int'({bus10.score_bcd, bus10.score_pulse}),
               int'({8'h01, 1'b1}));
    applyStimulus(1'b0, 1'b0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
      checkOutput("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
